// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: zero/SP init sweep, then round-robin over ex/ld(/dbg).
// Define RF_SCHED_DEBUG_EN to let the debug requester join the rotation.
module rf_write_sched #(
  parameter logic [31:0] SP_INIT  = 32'd1023,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_req,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [4:0]  dbg_rd,
  input  logic [31:0] dbg_data,
  output logic        rf_regWrite,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_writeData,
  output logic        init_done
);

`ifdef RF_SCHED_DEBUG_EN
  localparam int NREQ = 3;
`else
  localparam int NREQ = 2;
`endif
  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;

  logic [3:0]  vld;
  logic [3:0]  rdy;
  logic        gnt_any;
  logic [1:0]  gnt_idx;
  logic [2:0]  slot;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

`ifdef RF_SCHED_DEBUG_EN
  assign vld = {1'b0, dbg_valid, ld_valid, ex_valid};
`else
  assign vld = {2'b00, ld_valid, ex_valid};
  logic unused_dbg;
  assign unused_dbg = ^{dbg_valid, dbg_rd, dbg_data};
`endif

  // First valid slot at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    slot    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, ptr_q} + 3'(k);
      if (slot >= 3'(NREQ)) slot = slot - 3'(NREQ);
      if (!gnt_any && vld[slot[1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = slot[1:0];
      end
    end
  end

  always_comb begin
    rdy = 4'd0;
    if (state_q == S_RUN && !init_req && gnt_any) rdy = 4'd1 << gnt_idx;
  end

  assign ex_ready = rdy[0];
  assign ld_ready = rdy[1];
`ifdef RF_SCHED_DEBUG_EN
  assign dbg_ready = rdy[2];
`else
  assign dbg_ready = 1'b0;
`endif

  always_comb begin
    sel_rd   = ex_rd;
    sel_data = ex_data;
    case (gnt_idx)
      2'd1: begin sel_rd = ld_rd;  sel_data = ld_data;  end
      2'd2: begin sel_rd = dbg_rd; sel_data = dbg_data; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    done_d  = done_q;
    case (state_q)
      S_INIT: begin
        // x0 is strobed too; the register file drops writes to it.
        we_d   = 1'b1;
        rd_d   = cnt_q;
        data_d = (cnt_q == 5'd2) ? SP_INIT : 32'd0;
        if (init_req) begin
          cnt_d = 5'd0;
        end else if (cnt_q == LAST_REG) begin
          cnt_d   = 5'd0;
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_RUN: begin
        if (init_req) begin
          state_d = S_INIT;
          cnt_d   = 5'd0;
          done_d  = 1'b0;
        end else if (|rdy) begin
          we_d   = (sel_rd != 5'd0);
          rd_d   = sel_rd;
          data_d = sel_data;
          ptr_d  = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= 5'd0;
      ptr_q   <= 2'd0;
      we_q    <= 1'b0;
      rd_q    <= 5'd0;
      data_q  <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign rf_regWrite  = we_q;
  assign rf_rd        = rd_q;
  assign rf_writeData = data_q;
  assign init_done    = done_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Bench for rf_write_sched: behavioural model checked every cycle plus directed literal checks.
module tb_rf_write_sched;
`ifdef RF_SCHED_DEBUG_EN
  localparam int NR = 3;
`else
  localparam int NR = 2;
`endif
  localparam logic [31:0] SP = 32'd1023;

  logic clk = 1'b0, rst_n = 1'b0, init_req = 1'b0;
  logic ex_valid = 0, ld_valid = 0, dbg_valid = 0;
  logic ex_ready, ld_ready, dbg_ready;
  logic [4:0] ex_rd = 0, ld_rd = 0, dbg_rd = 0;
  logic [31:0] ex_data = 0, ld_data = 0, dbg_data = 0;
  logic rf_regWrite, init_done;
  logic [4:0] rf_rd;
  logic [31:0] rf_writeData;

  rf_write_sched dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .rf_regWrite(rf_regWrite), .rf_rd(rf_rd), .rf_writeData(rf_writeData),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: sweeping flag with next register index, rotation pointer, and expected outputs.
  bit m_run; int m_next; int m_ptr; bit m_we; int m_rd; logic [31:0] m_data; bit m_done;
  int last_g = -1;
  bit lr_ex, lr_ld, lr_dbg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_next = 0; m_ptr = 0; m_we = 0; m_rd = 0; m_data = 0; m_done = 0; last_g = -1;
  endtask

  function automatic int model_grant();
    bit v[3];
    v[0] = ex_valid; v[1] = ld_valid; v[2] = (NR == 3) ? dbg_valid : 1'b0;
    if (!m_run || init_req) return -1;
    for (int k = 0; k < NR; k++) if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  // Inputs are driven at negedge before calling; compares readies, then outputs after the edge.
  task automatic cycle();
    int g;
    #1;
    g = model_grant();
    lr_ex = ex_ready; lr_ld = ld_ready; lr_dbg = dbg_ready;
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, g == 0});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, g == 1});
    chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, g == 2});
    @(posedge clk); #1;
    if (!m_run) begin
      m_we = 1; m_rd = m_next; m_data = (m_next == 2) ? SP : 32'd0;
      if (init_req) m_next = 0;
      else if (m_next == 31) begin m_run = 1; m_done = 1; m_next = 0; end
      else m_next++;
    end else if (init_req) begin
      m_run = 0; m_next = 0; m_done = 0; m_we = 0;
    end else if (g >= 0) begin
      case (g)
        0: begin m_rd = ex_rd;  m_data = ex_data;  end
        1: begin m_rd = ld_rd;  m_data = ld_data;  end
        default: begin m_rd = dbg_rd; m_data = dbg_data; end
      endcase
      m_we = (m_rd != 0);
      m_ptr = (g + 1) % NR;
    end else m_we = 0;
    last_g = g;
    chk("rf_regWrite", {31'd0, rf_regWrite}, {31'd0, m_we});
    chk("rf_rd", {27'd0, rf_rd}, 32'(m_rd));
    chk("rf_writeData", rf_writeData, m_data);
    chk("init_done", {31'd0, init_done}, {31'd0, m_done});
    @(negedge clk);
  endtask

  task automatic drive_random();
    if (!(ex_valid && last_g != 0)) begin
      ex_valid = ($urandom_range(3) != 0); ex_rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      ex_data = $urandom;
    end
    if (!(ld_valid && last_g != 1)) begin
      ld_valid = ($urandom_range(2) != 0); ld_rd = 5'($urandom); ld_data = $urandom;
    end
    if (!(dbg_valid && last_g != 2)) begin
      dbg_valid = $urandom_range(1); dbg_rd = 5'($urandom); dbg_data = $urandom;
    end
    init_req = m_run && ($urandom_range(63) == 0);
  endtask

  int seq[6];
  int exp_seq[6];

  initial begin
    model_reset();
    #12;
    chk("rst_regWrite", {31'd0, rf_regWrite}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_data", rf_writeData, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset sweep with literal pins.
    for (int k = 0; k < 32; k++) begin
      cycle();
      chk("sweep_we", {31'd0, rf_regWrite}, 32'd1);
      chk("sweep_rd", {27'd0, rf_rd}, 32'(k));
      chk("sweep_data", rf_writeData, (k == 2) ? 32'd1023 : 32'd0);
      if (k < 31) chk("sweep_done_low", {31'd0, init_done}, 32'd0);
    end
    chk("sweep_done_high", {31'd0, init_done}, 32'd1);

    // Round-robin, all requesters continuously valid.
    ex_valid = 1; ex_rd = 5; ex_data = 32'hA;
    ld_valid = 1; ld_rd = 6; ld_data = 32'hB;
    dbg_valid = 1; dbg_rd = 7; dbg_data = 32'hC;
    for (int k = 0; k < 6; k++) begin cycle(); seq[k] = int'(rf_rd); end
    if (NR == 3) exp_seq = '{5, 6, 7, 5, 6, 7};
    else exp_seq = '{5, 6, 5, 6, 5, 6};
    for (int k = 0; k < 6; k++) chk("rr_seq", 32'(seq[k]), 32'(exp_seq[k]));
    ex_valid = 0; ld_valid = 0; dbg_valid = 0;
    cycle();

    // x0 suppression.
    ex_valid = 1; ex_rd = 0; ex_data = 32'hDEAD;
    cycle();
    chk("x0_ready", {31'd0, lr_ex}, 32'd1);
    chk("x0_no_strobe", {31'd0, rf_regWrite}, 32'd0);
    ex_valid = 0;
    cycle();

    // init_req collision with a pending load.
    ld_valid = 1; ld_rd = 9; ld_data = 32'h1234; init_req = 1;
    cycle();
    chk("coll_ld_ready", {31'd0, lr_ld}, 32'd0);
    chk("coll_done", {31'd0, init_done}, 32'd0);
    init_req = 0;
    for (int k = 0; k < 32; k++) begin
      cycle();
      chk("resweep_rd", {27'd0, rf_rd}, 32'(k));
      chk("resweep_ld_ready", {31'd0, lr_ld}, 32'd0);
    end
    cycle();
    chk("coll_ld_accept", {31'd0, lr_ld}, 32'd1);
    chk("coll_ld_write", {27'd0, rf_rd}, 32'd9);
    ld_valid = 0;

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin drive_random(); cycle(); end
    init_req = 0;

    // Async reset between edges with a pending ex request.
    ex_valid = 1; ex_rd = 3; ex_data = 32'h55;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, rf_regWrite}, 32'd0);
    chk("arst_rd", {27'd0, rf_rd}, 32'd0);
    chk("arst_data", rf_writeData, 32'd0);
    chk("arst_done", {31'd0, init_done}, 32'd0);
    chk("arst_ready", {31'd0, ex_ready}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    cycle();
    chk("arst_sweep0", {27'd0, rf_rd}, 32'd0);
    chk("arst_sweep0_we", {31'd0, rf_regWrite}, 32'd1);
    for (int k = 1; k < 40; k++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
